// File: rtl/pcileech_cfgspace_pkg.sv
// Shared types and helpers for the shadow config-space BRAM arbiter.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package pcileech_cfgspace_pkg;

   localparam int CFGSPACE_ADDR_W = 10;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_TLP  = 2'd1,
      REQ_USB  = 2'd2,
      REQ_INT  = 2'd3
   } cfgspace_req_t;

   // One slot of the response pipeline: who asked, and with which tag.
   typedef struct packed {
      logic          valid;
      cfgspace_req_t req;
      logic [7:0]    tag;
   } cfgspace_pipe_ent_t;

   // Requester index (0 = tlp, 1 = usb, 2 = int, 3 = nobody) to enum.
   function automatic cfgspace_req_t idx_to_req(input logic [1:0] idx);
      case (idx)
         2'd0:    return REQ_TLP;
         2'd1:    return REQ_USB;
         2'd2:    return REQ_INT;
         default: return REQ_NONE;
      endcase
   endfunction

   // Rotating-priority pick starting at 'start'; returns 3 when no candidate.
   function automatic logic [1:0] arb_pick(input logic [2:0] cand, input logic [1:0] start);
      logic [1:0] pick;
      logic [2:0] sum;
      pick = 2'd3;
      // Walk from lowest to highest priority so the highest one wins last.
      for (int k = 2; k >= 0; k--) begin
         sum = {1'b0, start} + 3'(k);
         if (sum >= 3'd3) sum = sum - 3'd3;
         if (cand[sum[1:0]]) pick = sum[1:0];
      end
      return pick;
   endfunction

   // Requester following 'idx' in the tlp -> usb -> int -> tlp ring.
   function automatic logic [1:0] next_idx(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/pcileech_cfgspace_rsp_pipe.sv
// Tag/requester delay line for one BRAM port, demuxed to per-requester strobes.
// Latency: RD_LATENCY cycles from in_ent to out_valid/out_tag.
// Backpressure: none; a new entry can enter every cycle.
module pcileech_cfgspace_rsp_pipe
   import pcileech_cfgspace_pkg::*;
#(
   parameter int RD_LATENCY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  cfgspace_pipe_ent_t in_ent,
   output logic [2:0]         out_valid,
   output logic [7:0]         out_tag
);

   cfgspace_pipe_ent_t stage [RD_LATENCY];

   // Shift the entry along; reset flushes anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) stage[i] <= '0;
      end else begin
         stage[0] <= in_ent;
         for (int i = 1; i < RD_LATENCY; i++) stage[i] <= stage[i-1];
      end
   end

   // Route the oldest entry to its requester; silent while in reset.
   always_comb begin
      out_valid = 3'b000;
      out_tag   = 8'h00;
      if (!rst && stage[RD_LATENCY-1].valid) begin
         out_tag = stage[RD_LATENCY-1].tag;
         case (stage[RD_LATENCY-1].req)
            REQ_TLP: out_valid[0] = 1'b1;
            REQ_USB: out_valid[1] = 1'b1;
            REQ_INT: out_valid[2] = 1'b1;
            default: out_valid = 3'b000;
         endcase
      end
   end

endmodule

// File: rtl/pcileech_cfgspace_arbiter.sv
// Lossless 3-requester arbiter for the shadow cfg-space BRAM write and read ports.
// Latency: request accepted in cycle t responds in cycle t+RD_LATENCY (reads and writes).
// Backpressure: per-requester ready; held requests wait, same-DWORD read-after-write defers the read.
// Optional PCILEECH_CFGSPACE_ARB_RR_EN: round-robin per port instead of fixed tlp > usb > int.
module pcileech_cfgspace_arbiter
   import pcileech_cfgspace_pkg::*;
#(
   parameter int RD_LATENCY  = 2,
   parameter int STALL_CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tlp_req_valid,
   output logic                       tlp_req_ready,
   input  logic                       tlp_req_wr,
   input  logic [CFGSPACE_ADDR_W-1:0] tlp_req_addr,
   input  logic [3:0]                 tlp_req_be,
   input  logic [31:0]                tlp_req_data,
   input  logic [7:0]                 tlp_req_tag,
   output logic                       tlp_rsp_valid,
   output logic                       tlp_rsp_wr,
   output logic [7:0]                 tlp_rsp_tag,
   output logic [31:0]                tlp_rsp_data,
   input  logic                       usb_req_valid,
   output logic                       usb_req_ready,
   input  logic                       usb_req_wr,
   input  logic [CFGSPACE_ADDR_W-1:0] usb_req_addr,
   input  logic [3:0]                 usb_req_be,
   input  logic [31:0]                usb_req_data,
   input  logic [7:0]                 usb_req_tag,
   output logic                       usb_rsp_valid,
   output logic                       usb_rsp_wr,
   output logic [7:0]                 usb_rsp_tag,
   output logic [31:0]                usb_rsp_data,
   input  logic                       int_req_valid,
   output logic                       int_req_ready,
   input  logic                       int_req_wr,
   input  logic [CFGSPACE_ADDR_W-1:0] int_req_addr,
   input  logic [3:0]                 int_req_be,
   input  logic [31:0]                int_req_data,
   input  logic [7:0]                 int_req_tag,
   output logic                       int_rsp_valid,
   output logic                       int_rsp_wr,
   output logic [7:0]                 int_rsp_tag,
   output logic [31:0]                int_rsp_data,
   input  logic                       cfg_zero,
   output logic [3:0]                 bram_wea,
   output logic [CFGSPACE_ADDR_W-1:0] bram_addra,
   output logic [31:0]                bram_dina,
   output logic [CFGSPACE_ADDR_W-1:0] bram_addrb,
   input  logic [31:0]                bram_doutb,
   output logic [STALL_CNT_W-1:0]     stall_cnt
);

   // Requester-indexed views: 0 = tlp, 1 = usb, 2 = int.
   logic [2:0]                 vld, wr, ready;
   logic [CFGSPACE_ADDR_W-1:0] addr [3];
   logic [3:0]                 be   [3];
   logic [31:0]                data [3];
   logic [7:0]                 tag  [3];

   assign vld = {int_req_valid, usb_req_valid, tlp_req_valid};
   assign wr  = {int_req_wr,    usb_req_wr,    tlp_req_wr};
   assign addr[0] = tlp_req_addr; assign addr[1] = usb_req_addr; assign addr[2] = int_req_addr;
   assign be[0]   = tlp_req_be;   assign be[1]   = usb_req_be;   assign be[2]   = int_req_be;
   assign data[0] = tlp_req_data; assign data[1] = usb_req_data; assign data[2] = int_req_data;
   assign tag[0]  = tlp_req_tag;  assign tag[1]  = usb_req_tag;  assign tag[2]  = int_req_tag;

   logic [1:0] w_idx, r_idx, wr_ptr, rd_ptr;
   logic       w_gnt, r_gnt;

`ifdef PCILEECH_CFGSPACE_ARB_RR_EN
   logic [1:0] wr_ptr_q, rd_ptr_q;

   // Each port's pointer moves past its last winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 2'd0;
         rd_ptr_q <= 2'd0;
      end else begin
         if (w_gnt) wr_ptr_q <= next_idx(w_idx);
         if (r_gnt) rd_ptr_q <= next_idx(r_idx);
      end
   end

   assign wr_ptr = wr_ptr_q;
   assign rd_ptr = rd_ptr_q;
`else
   assign wr_ptr = 2'd0;
   assign rd_ptr = 2'd0;
`endif

   // Pick one writer and one reader; a read hitting the write's DWORD waits a cycle.
   always_comb begin
      w_idx = arb_pick(vld & wr, wr_ptr);
      r_idx = arb_pick(vld & ~wr, rd_ptr);
      w_gnt = !rst && (w_idx != 2'd3);
      r_gnt = !rst && (r_idx != 2'd3);
      if (w_gnt && r_gnt && (addr[r_idx] == addr[w_idx])) r_gnt = 1'b0;
   end

   // Drive BRAM ports and readies from the grants; idle ports sit at zero.
   always_comb begin
      ready      = 3'b000;
      bram_wea   = 4'h0;
      bram_addra = '0;
      bram_dina  = 32'h0;
      bram_addrb = '0;
      if (w_gnt) begin
         ready[w_idx] = 1'b1;
         bram_wea     = be[w_idx];
         bram_addra   = addr[w_idx];
         bram_dina    = data[w_idx];
      end
      if (r_gnt) begin
         ready[r_idx] = 1'b1;
         bram_addrb   = addr[r_idx];
      end
   end

   assign tlp_req_ready = ready[0];
   assign usb_req_ready = ready[1];
   assign int_req_ready = ready[2];

   cfgspace_pipe_ent_t rd_ent, wr_ent;
   logic [2:0]         rd_v, wr_v;
   logic [7:0]         rd_tag, wr_tag;

   assign rd_ent = '{valid: r_gnt, req: r_gnt ? idx_to_req(r_idx) : REQ_NONE,
                     tag: r_gnt ? tag[r_idx] : 8'h00};
   assign wr_ent = '{valid: w_gnt, req: w_gnt ? idx_to_req(w_idx) : REQ_NONE,
                     tag: w_gnt ? tag[w_idx] : 8'h00};

   pcileech_cfgspace_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_pipe (
      .clk(clk), .rst(rst), .in_ent(rd_ent), .out_valid(rd_v), .out_tag(rd_tag)
   );

   pcileech_cfgspace_rsp_pipe #(.RD_LATENCY(RD_LATENCY)) u_wr_pipe (
      .clk(clk), .rst(rst), .in_ent(wr_ent), .out_valid(wr_v), .out_tag(wr_tag)
   );

   // A requester never sees a read response and a write ack in the same cycle.
   assign tlp_rsp_valid = rd_v[0] | wr_v[0];
   assign tlp_rsp_wr    = wr_v[0];
   assign tlp_rsp_tag   = wr_v[0] ? wr_tag : (rd_v[0] ? rd_tag : 8'h00);
   assign tlp_rsp_data  = (rd_v[0] && !cfg_zero) ? bram_doutb : 32'h0;

   assign usb_rsp_valid = rd_v[1] | wr_v[1];
   assign usb_rsp_wr    = wr_v[1];
   assign usb_rsp_tag   = wr_v[1] ? wr_tag : (rd_v[1] ? rd_tag : 8'h00);
   assign usb_rsp_data  = (rd_v[1] && !cfg_zero) ? bram_doutb : 32'h0;

   assign int_rsp_valid = rd_v[2] | wr_v[2];
   assign int_rsp_wr    = wr_v[2];
   assign int_rsp_tag   = wr_v[2] ? wr_tag : (rd_v[2] ? rd_tag : 8'h00);
   assign int_rsp_data  = (rd_v[2] && !cfg_zero) ? bram_doutb : 32'h0;

   // Count cycles where any presented request was left waiting; stick at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (|(vld & ~ready) && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: doc/pcileech_cfgspace_arbiter.md
# pcileech_cfgspace_arbiter

Lossless arbiter/scheduler for the 4 kB shadow configuration space BRAM. It shares the BRAM's independent write port and read port among three requesters: PCIe TLP, USB/FIFO and internal. Requests are held with a valid/ready handshake instead of being dropped on collision. Every accepted read returns data, and every accepted write returns an acknowledge, tagged and routed back to the originating requester after a fixed latency.

## Interface
Parameters:
- RD_LATENCY, 2, BRAM read latency in cycles from addrb to doutb; legal range 1–4
- STALL_CNT_W, 16, width of the saturating stall counter

Ports (r ∈ {tlp, usb, int}; each requester carries its own copy of the r_ ports):
- clk  in  1  single clock for all logic and the BRAM
- rst  in  1  synchronous, active-high reset
- r_req_valid  in  1  request present
- r_req_ready  out  1  request accepted this cycle when high together with r_req_valid
- r_req_wr  in  1  1 = write, 0 = read
- r_req_addr  in  10  DWORD address
- r_req_be  in  4  byte enables; writes only
- r_req_data  in  32  write data
- r_req_tag  in  8  opaque tag, returned with the response
- r_rsp_valid  out  1  one-cycle response pulse; no backpressure
- r_rsp_wr  out  1  1 = write ack, 0 = read data
- r_rsp_tag  out  8  tag of the completed request
- r_rsp_data  out  32  read data; 0 for write acks
- cfg_zero  in  1  forces read response data to 0
- bram_wea  out  4
- bram_addra  out  10
- bram_dina  out  32
- bram_addrb  out  10
- bram_doutb  in  32
- stall_cnt  out  STALL_CNT_W  saturating count of cycles in which at least one valid request was not granted

## Operation
- Each cycle the block grants at most one write (write port) and at most one read (read port), so at most two different requesters are granted per cycle.
- Write candidates: r_req_valid & r_req_wr. Read candidates: r_req_valid & ~r_req_wr.
- Default arbitration is fixed priority: tlp > usb > int, applied independently on each port.
- Granted write: bram_wea = be, bram_addra = addr, bram_dina = data. Ungranted cycles drive bram_wea = 0.
- Granted read: bram_addrb = addr, driven combinationally from the granted request in the same cycle.
- Write with be = 4'b0000 is still granted and acknowledged; the BRAM contents are unchanged.
- Address hazard: if the winning read and the winning write address the same DWORD in the same cycle, the read is not granted that cycle; the requester's ready stays low. The read is granted on a later cycle and returns the post-write data.
- Response pipeline: a RD_LATENCY-deep shift register per port carries {valid, requester, tag}. Its output drives the r_rsp_* signals.
  - Read responses and write acks always target different requesters in the same cycle, because each requester issues at most one request per cycle.
- cfg_zero is sampled on the response cycle, not the issue cycle.
- stall_cnt increments by 1 in any cycle where some r_req_valid is high with r_req_ready low. It saturates at all-ones.

## Timing
- Reset values:
  - all r_req_ready = 0 and all r_rsp_valid = 0
  - rsp tag/data/wr = 0
  - bram_wea = 0; bram_addra, bram_dina, bram_addrb = 0
  - stall_cnt = 0
  - response pipeline cleared
  - round-robin pointers at tlp
- r_req_ready is combinational from valid, wr, addr and arbitration state. It is forced low while rst = 1.
- Request accepted in cycle t → response pulse in cycle t + RD_LATENCY, for both reads and writes.
- Throughput is one read plus one write per cycle sustained.
- A requester holds its request stable until it is accepted.
- Reset asserted mid-operation: in-flight responses are discarded and never emitted. Responses resume only for requests accepted after reset deasserts.

## Configuration
- Macro: PCILEECH_CFGSPACE_ARB_RR_EN.
- When defined: each port keeps a round-robin pointer. After a grant, that port's pointer moves to the requester following the winner. Any continuously valid requester is granted within 3 competing grants on its port.
- When undefined: fixed priority tlp > usb > int, with no pointer state. The int requester may starve.

## Structure
- Package pcileech_cfgspace_pkg holds:
  - typedef enum logic [1:0] cfgspace_req_t {REQ_NONE, REQ_TLP, REQ_USB, REQ_INT}
  - the pipeline entry struct {valid, req, tag}
  - CFGSPACE_ADDR_W = 10
- Sub-module pcileech_cfgspace_rsp_pipe: parameterised by RD_LATENCY. It is instantiated twice, once for the read path and once for the write path. It implements the shift register and the demux to per-requester response signals.

## Test plan
- tlp read addr 0x004 tag 0x11, BRAM preloaded with 0xDEADBEEF at 0x004 → tlp_rsp_valid at t+2 with tag 0x11 and data 0xDEADBEEF.
- tlp write and usb write in the same cycle → tlp granted at t and usb at t+1. Both acks are returned, and stall_cnt = 1.
- usb write 0x12345678 be 4'b0011 to 0x010 with simultaneous int read of 0x010 → int read deferred one cycle; read returns the old upper 16 bits with 0x5678 in the lower 16 bits.
- cfg_zero = 1 during a tlp read of a nonzero word → rsp_data = 0; tag and valid are unchanged.
- With PCILEECH_CFGSPACE_ARB_RR_EN, all three requesters issue continuous reads → grant order tlp, usb, int, tlp…; without the macro, int is never granted.
- rst pulsed one cycle after a read is accepted → no rsp_valid follows, and all outputs hold their reset values.
